lieat_general_pipebuf: RTL and testbench
========================================

Name: lieat_general_pipebuf

Overview:
- Parametrised valid/ready pipeline buffer and successor to the single-entry stage register.
- Holds DEPTH entries of DW bits in a circular buffer.
- Selectable ready-path cutting, optional zero-latency bypass, output masking and synchronous flush.
- Placed between pipe stages wherever more than one slot of elasticity or a timing cut on ready is needed.

Parameters:
- DW, 32: data width in bits, must be >= 1.
- DEPTH, 2: number of entries, must be >= 1; need not be a power of two.
- CUT_READY, 1: 1 gives i_ready = ~full (no o_ready->i_ready path); 0 gives i_ready = ~full | o_ready.
- BYPASS, 0: 1 lets data pass combinationally when the buffer is empty and o_ready=1; 0 gives a fixed latency of 1 cycle.
- MASK, 0: 1 drives o_data to all-zero whenever o_valid=0.
- CW, $clog2(DEPTH+1): width of count; derived, not to be overridden.

Ports:
- clk  input  1  clock, all state on rising edge.
- rstn  input  1  synchronous reset, active-low.
- flush  input  1  synchronous clear of all entries.
- i_valid  input  1  upstream valid.
- i_ready  output  1  upstream ready.
- i_data  input  DW  upstream data.
- o_valid  output  1  downstream valid.
- o_ready  input  1  downstream ready.
- o_data  output  DW  downstream data.
- count  output  CW  number of stored entries.

Behaviour:
- Reset and clock: single clock domain; reset is synchronous and active-low (rstn sampled on the rising clk edge).
- Reset state: wr_ptr=0, rd_ptr=0, count=0, o_valid=0, i_ready=1 (when flush=0).
- Data RAM: the data array is not reset; its contents are don't-care until written.
- Handshakes: i_hs = i_valid & i_ready; o_hs = o_valid & o_ready.
- Flow: empty = (count==0); full = (count==DEPTH).
- o_valid = ~empty, or, if BYPASS=1, ~empty | i_valid.
- o_data = mem[rd_ptr] when ~empty; i_data when empty and BYPASS=1.
- Applying MASK: o_data is ANDed with {DW{o_valid}}.
- Bypass (BYPASS=1): when empty & i_hs & o_hs, the item is not stored and the pointers and count are unchanged.
- Write: on a stored i_hs, mem[wr_ptr] <= i_data and wr_ptr advances.
- Read: on an o_hs from storage, rd_ptr advances.
- Pointer wrap: pointers wrap from DEPTH-1 to 0 explicitly, with no power-of-two assumption.
- Count: next count = count + stored_write - stored_read.
- Simultaneous push and pop: count is unchanged.
- Push while full: only legal with CUT_READY=0 and o_ready=1; the read and write occur in the same cycle.
- Ordering: strict FIFO; no item is dropped or duplicated.
- Latency: 1 cycle from i_hs to o_valid when BYPASS=0, or 0 cycles on the bypass path.
- Throughput: one item per cycle when DEPTH>=2, or when DEPTH=1 with CUT_READY=0.
  - DEPTH=1 with CUT_READY=1 gives 1/2 throughput; this is accepted behaviour.
- Flush: while flush=1, i_ready=0 and o_valid=0 combinationally, so no handshake is possible.
  - On the next edge, pointers and count are cleared to 0.
  - Flush has priority over all traffic.
- Reset priority: rstn=0 overrides flush.
- Reset mid-operation: all in-flight items are discarded and the reset state holds the following cycle.
- Protocol: o_valid, once asserted from storage, holds with stable data until o_hs or flush.
  - The upstream must not retract i_valid; this is not checked.

Optional Feature:
- Macro: LIEAT_PIPEBUF_PEAK_EN.
- Defined:
  - Adds output port peak [CW-1:0], a high-water mark of count.
  - Each cycle, peak <= max(peak, next count).
  - peak resets to 0 on rstn=0 or flush=1.
- Undefined: the port and its register are absent; all other behaviour is identical.

Test Plan:
- Reset and fill: DEPTH=4, BYPASS=0, hold rstn=0 for 2 cycles, then push 0x11,0x22,0x33,0x44 with o_ready=0.
  - Expect count=4 and i_ready=0.
  - Then set o_ready=1: expect o_data sequence 0x11,0x22,0x33,0x44 on consecutive cycles and count back to 0.
- Streaming: DEPTH=2, i_valid=o_ready=1 for 100 cycles with an incrementing pattern.
  - Expect one output per cycle, first output 1 cycle after first input, count steady at 1.
- Non-power-of-two wrap: DEPTH=3, 10 push/pop pairs with random stalls.
  - Expect the output order to equal the input order across pointer wraps and count never above 3.
- Full pass-through: CUT_READY=0, DEPTH=1, buffer full with o_ready=1 and i_valid=1.
  - Expect i_ready=1, simultaneous pop and push, count stays 1.
  - With CUT_READY=1 under the same stimulus, expect i_ready=0.
- Bypass: BYPASS=1, empty buffer, i_valid=1, i_data=0xA5, o_ready=1.
  - Expect o_valid=1 and o_data=0xA5 in the same cycle, count stays 0.
- Flush, MASK and PEAK: MASK=1, macro defined, fill 3 entries, then pulse flush.
  - During the flush cycle expect o_valid=0, o_data=0, i_ready=0.
  - Next cycle expect count=0 and peak=0; peak equals 3 before the flush.

Source files
------------

// File: rtl/lieat_general_pipebuf.sv
// lieat_general_pipebuf: DEPTH-entry valid/ready elastic buffer (circular RAM).
// Selectable ready-path cut, optional zero-latency bypass, output masking and
// synchronous flush. Optional feature macro: LIEAT_PIPEBUF_PEAK_EN adds the
// 'peak' output, a high-water mark of the stored-entry count.
module lieat_general_pipebuf #(
  parameter int DW        = 32,
  parameter int DEPTH     = 2,
  parameter int CUT_READY = 1,
  parameter int BYPASS    = 0,
  parameter int MASK      = 0,
  parameter int CW        = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          i_valid,
  output logic          i_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          o_ready,
  output logic [DW-1:0] o_data,
  output logic [CW-1:0] count
`ifdef LIEAT_PIPEBUF_PEAK_EN
  ,
  output logic [CW-1:0] peak
`endif
);

  // Pointer width; a single-entry buffer still carries a 1-bit pointer.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty_s;
  logic          full_s;
  logic          i_hs_s;
  logic          o_hs_s;
  logic          bypass_s;
  logic          wr_en_s;
  logic          rd_en_s;
  logic [DW-1:0] o_data_raw_s;

  // Status flags, handshakes and the combinational output face of the buffer.
  always_comb begin
    empty_s = (count_q == {CW{1'b0}});
    full_s  = (count_q == DEPTH_C);

    // Flush blanks both handshakes so nothing can move while clearing.
    if (flush) begin
      i_ready = 1'b0;
    end else if (CUT_READY != 0) begin
      i_ready = ~full_s;
    end else begin
      i_ready = ~full_s | o_ready;
    end

    if (flush) begin
      o_valid = 1'b0;
    end else if (BYPASS != 0) begin
      o_valid = ~empty_s | i_valid;
    end else begin
      o_valid = ~empty_s;
    end

    if ((BYPASS != 0) && empty_s) begin
      o_data_raw_s = i_data;
    end else begin
      o_data_raw_s = mem_q[rd_ptr_q];
    end

    if (MASK != 0) begin
      o_data = o_data_raw_s & {DW{o_valid}};
    end else begin
      o_data = o_data_raw_s;
    end

    i_hs_s   = i_valid & i_ready;
    o_hs_s   = o_valid & o_ready;
    // An item that enters and leaves while empty never touches storage.
    bypass_s = (BYPASS != 0) && empty_s && i_hs_s && o_hs_s;
    wr_en_s  = i_hs_s & ~bypass_s;
    rd_en_s  = o_hs_s & ~empty_s;
  end

  // Next pointers (explicit wrap, DEPTH need not be a power of two) and count.
  always_comb begin
    if (wr_en_s) begin
      if (wr_ptr_q == PTR_LAST) begin
        wr_ptr_d = {PW{1'b0}};
      end else begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (rd_en_s) begin
      if (rd_ptr_q == PTR_LAST) begin
        rd_ptr_d = {PW{1'b0}};
      end else begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case ({wr_en_s, rd_en_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state: reset beats flush, flush beats traffic.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else if (flush) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {CW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Data storage; intentionally not reset, contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= i_data;
    end
  end

  assign count = count_q;

`ifdef LIEAT_PIPEBUF_PEAK_EN
  logic [CW-1:0] peak_q, peak_d;

  // High-water mark tracks the count that will be stored after this edge.
  always_comb begin
    if (count_d > peak_q) begin
      peak_d = count_d;
    end else begin
      peak_d = peak_q;
    end
  end

  // Peak register, cleared together with the buffer.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      peak_q <= {CW{1'b0}};
    end else if (flush) begin
      peak_q <= {CW{1'b0}};
    end else begin
      peak_q <= peak_d;
    end
  end

  assign peak = peak_q;
`endif

endmodule

// File: tb/tb_lieat_general_pipebuf.sv
// Directed bench for lieat_general_pipebuf: several parameterisations share one
// stimulus bus; each test sequence checks the instance it targets.
module tb_lieat_general_pipebuf;

  logic       clk;
  logic       rstn;
  logic       flush;
  logic       iv;
  logic       ordy;
  logic [7:0] id;

  int n_cmp;
  int n_bad;

  // A: DEPTH=4 fill/drain
  logic a_ir, a_ov; logic [7:0] a_od; logic [2:0] a_cnt;
  // B: DEPTH=2 streaming
  logic b_ir, b_ov; logic [7:0] b_od; logic [1:0] b_cnt;
  // C: DEPTH=3 wrap
  logic c_ir, c_ov; logic [7:0] c_od; logic [1:0] c_cnt;
  // D: DEPTH=1 CUT_READY=0 ; E: DEPTH=1 CUT_READY=1
  logic d_ir, d_ov; logic [7:0] d_od; logic [0:0] d_cnt;
  logic e_ir, e_ov; logic [7:0] e_od; logic [0:0] e_cnt;
  // F: BYPASS=1
  logic f_ir, f_ov; logic [7:0] f_od; logic [1:0] f_cnt;
  // G: MASK=1 DEPTH=4 (plus peak when enabled)
  logic g_ir, g_ov; logic [7:0] g_od; logic [2:0] g_cnt;
`ifdef LIEAT_PIPEBUF_PEAK_EN
  logic [2:0] g_peak;
`endif

  lieat_general_pipebuf #(.DW(8), .DEPTH(4), .CUT_READY(1), .BYPASS(0), .MASK(0)) u_a (
    .clk(clk), .rstn(rstn), .flush(flush), .i_valid(iv), .i_ready(a_ir), .i_data(id),
    .o_valid(a_ov), .o_ready(ordy), .o_data(a_od), .count(a_cnt)
`ifdef LIEAT_PIPEBUF_PEAK_EN
    , .peak()
`endif
  );
  lieat_general_pipebuf #(.DW(8), .DEPTH(2), .CUT_READY(1), .BYPASS(0), .MASK(0)) u_b (
    .clk(clk), .rstn(rstn), .flush(flush), .i_valid(iv), .i_ready(b_ir), .i_data(id),
    .o_valid(b_ov), .o_ready(ordy), .o_data(b_od), .count(b_cnt)
`ifdef LIEAT_PIPEBUF_PEAK_EN
    , .peak()
`endif
  );
  lieat_general_pipebuf #(.DW(8), .DEPTH(3), .CUT_READY(1), .BYPASS(0), .MASK(0)) u_c (
    .clk(clk), .rstn(rstn), .flush(flush), .i_valid(iv), .i_ready(c_ir), .i_data(id),
    .o_valid(c_ov), .o_ready(ordy), .o_data(c_od), .count(c_cnt)
`ifdef LIEAT_PIPEBUF_PEAK_EN
    , .peak()
`endif
  );
  lieat_general_pipebuf #(.DW(8), .DEPTH(1), .CUT_READY(0), .BYPASS(0), .MASK(0)) u_d (
    .clk(clk), .rstn(rstn), .flush(flush), .i_valid(iv), .i_ready(d_ir), .i_data(id),
    .o_valid(d_ov), .o_ready(ordy), .o_data(d_od), .count(d_cnt)
`ifdef LIEAT_PIPEBUF_PEAK_EN
    , .peak()
`endif
  );
  lieat_general_pipebuf #(.DW(8), .DEPTH(1), .CUT_READY(1), .BYPASS(0), .MASK(0)) u_e (
    .clk(clk), .rstn(rstn), .flush(flush), .i_valid(iv), .i_ready(e_ir), .i_data(id),
    .o_valid(e_ov), .o_ready(ordy), .o_data(e_od), .count(e_cnt)
`ifdef LIEAT_PIPEBUF_PEAK_EN
    , .peak()
`endif
  );
  lieat_general_pipebuf #(.DW(8), .DEPTH(2), .CUT_READY(1), .BYPASS(1), .MASK(0)) u_f (
    .clk(clk), .rstn(rstn), .flush(flush), .i_valid(iv), .i_ready(f_ir), .i_data(id),
    .o_valid(f_ov), .o_ready(ordy), .o_data(f_od), .count(f_cnt)
`ifdef LIEAT_PIPEBUF_PEAK_EN
    , .peak()
`endif
  );
  lieat_general_pipebuf #(.DW(8), .DEPTH(4), .CUT_READY(1), .BYPASS(0), .MASK(1)) u_g (
    .clk(clk), .rstn(rstn), .flush(flush), .i_valid(iv), .i_ready(g_ir), .i_data(id),
    .o_valid(g_ov), .o_ready(ordy), .o_data(g_od), .count(g_cnt)
`ifdef LIEAT_PIPEBUF_PEAK_EN
    , .peak(g_peak)
`endif
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something stalls the sequence.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rstn = 1'b0; flush = 1'b0; iv = 1'b0; ordy = 1'b0; id = 8'h00;
    step();
    step();
    rstn = 1'b1;
  endtask

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       ex_ov;
    logic       chk_od;
    logic [7:0] ex_od;
    logic [2:0] ex_cnt;
    logic       ex_ir;
  } vec_t;

  vec_t tbl [10];

  logic [7:0] q [$];
  int         popped;
  int         cyc;
  logic [7:0] nxt;
  logic       in_hs;
  logic       out_hs;

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rstn = 1'b0; flush = 1'b0; iv = 1'b0; ordy = 1'b0; id = 8'h00;

    // Fill A to full with o_ready low (0x55 refused when full), then drain.
    tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 3'd1, 1'b1};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 3'd2, 1'b1};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 3'd3, 1'b1};
    tbl[4] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 8'h11, 3'd4, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 3'd4, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3'd3, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 3'd2, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 3'd1, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 3'd0, 1'b1};

    // ---- reset state ----
    do_reset();
    #1;
    chk("rst_cnt", 32'(a_cnt), 32'd0);
    chk("rst_ir", 32'(a_ir), 32'd1);
    chk("rst_ov", 32'(a_ov), 32'd0);
    chk("rst_g_od", 32'(g_od), 32'd0);
`ifdef LIEAT_PIPEBUF_PEAK_EN
    chk("rst_peak", 32'(g_peak), 32'd0);
`endif

    // ---- table: fill and drain on DEPTH=4 ----
    for (int i = 0; i < 10; i++) begin
      iv = tbl[i].iv; id = tbl[i].id; ordy = tbl[i].ordy;
      #1;
      chk($sformatf("fill_ov[%0d]", i), 32'(a_ov), 32'(tbl[i].ex_ov));
      chk($sformatf("fill_cnt[%0d]", i), 32'(a_cnt), 32'(tbl[i].ex_cnt));
      chk($sformatf("fill_ir[%0d]", i), 32'(a_ir), 32'(tbl[i].ex_ir));
      if (tbl[i].chk_od) begin
        chk($sformatf("fill_od[%0d]", i), 32'(a_od), 32'(tbl[i].ex_od));
      end
      step();
    end

    // ---- streaming on DEPTH=2 ----
    do_reset();
    for (int k = 0; k < 100; k++) begin
      iv = 1'b1; ordy = 1'b1; id = 8'(k);
      #1;
      chk("strm_ir", 32'(b_ir), 32'd1);
      if (k == 0) begin
        chk("strm_ov0", 32'(b_ov), 32'd0);
        chk("strm_cnt0", 32'(b_cnt), 32'd0);
      end else begin
        chk("strm_ov", 32'(b_ov), 32'd1);
        chk("strm_od", 32'(b_od), 32'(8'(k - 1)));
        chk("strm_cnt", 32'(b_cnt), 32'd1);
      end
      step();
    end

    // ---- DEPTH=3 wrap with random stalls against a queue model ----
    do_reset();
    q.delete();
    popped = 0;
    nxt = 8'h80;
    cyc = 0;
    while (popped < 10 && cyc < 400) begin
      iv = 1'($urandom_range(0, 1)); ordy = 1'($urandom_range(0, 1)); id = nxt;
      #1;
      chk("wrap_cnt", 32'(c_cnt), 32'(q.size()));
      chk("wrap_ir", 32'(c_ir), 32'(q.size() < 3));
      chk("wrap_ov", 32'(c_ov), 32'(q.size() != 0));
      out_hs = (q.size() != 0) && ordy;
      in_hs  = iv && (q.size() < 3);
      if (out_hs) begin
        chk("wrap_od", 32'(c_od), 32'(q[0]));
        void'(q.pop_front());
        popped++;
      end
      if (in_hs) begin
        q.push_back(nxt);
        nxt = nxt + 8'd1;
      end
      step();
      cyc++;
    end
    chk("wrap_done", 32'(popped), 32'd10);

    // ---- DEPTH=1 full pass-through, CUT_READY=0 (D) vs 1 (E) ----
    do_reset();
    iv = 1'b1; id = 8'h5A; ordy = 1'b0;
    step();
    iv = 1'b1; id = 8'h6B; ordy = 1'b1;
    #1;
    chk("pt_d_ir", 32'(d_ir), 32'd1);
    chk("pt_d_od", 32'(d_od), 32'h5A);
    chk("pt_d_cnt", 32'(d_cnt), 32'd1);
    chk("pt_e_ir", 32'(e_ir), 32'd0);
    chk("pt_e_od", 32'(e_od), 32'h5A);
    step();
    iv = 1'b1; id = 8'h7C; ordy = 1'b1;
    #1;
    chk("pt_d_cnt2", 32'(d_cnt), 32'd1);
    chk("pt_d_od2", 32'(d_od), 32'h6B);
    chk("pt_d_ir2", 32'(d_ir), 32'd1);
    chk("pt_e_cnt2", 32'(e_cnt), 32'd0);
    chk("pt_e_ov2", 32'(e_ov), 32'd0);
    step();
    iv = 1'b0; ordy = 1'b1;
    #1;
    chk("pt_d_od3", 32'(d_od), 32'h7C);
    chk("pt_e_od3", 32'(e_od), 32'h7C);
    chk("pt_e_ir3", 32'(e_ir), 32'd0);
    step();

    // ---- bypass ----
    do_reset();
    iv = 1'b1; id = 8'hA5; ordy = 1'b1;
    #1;
    chk("byp_ov", 32'(f_ov), 32'd1);
    chk("byp_od", 32'(f_od), 32'hA5);
    chk("byp_cnt", 32'(f_cnt), 32'd0);
    step();
    iv = 1'b0;
    #1;
    chk("byp_cnt_after", 32'(f_cnt), 32'd0);
    chk("byp_ov_after", 32'(f_ov), 32'd0);
    iv = 1'b1; id = 8'h3C; ordy = 1'b0;
    #1;
    chk("byp_stall_od", 32'(f_od), 32'h3C);
    step();
    iv = 1'b0; ordy = 1'b1;
    #1;
    chk("byp_store_cnt", 32'(f_cnt), 32'd1);
    chk("byp_store_od", 32'(f_od), 32'h3C);
    step();
    chk("byp_drain_cnt", 32'(f_cnt), 32'd0);

    // ---- MASK, flush and peak on G ----
    do_reset();
    ordy = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      iv = 1'b1; id = 8'(i);
      step();
    end
    iv = 1'b0;
    #1;
    chk("fl_pre_cnt", 32'(g_cnt), 32'd3);
    chk("fl_pre_od", 32'(g_od), 32'h01);
`ifdef LIEAT_PIPEBUF_PEAK_EN
    chk("fl_pre_peak", 32'(g_peak), 32'd3);
`endif
    flush = 1'b1; iv = 1'b1; id = 8'h99; ordy = 1'b1;
    #1;
    chk("fl_ov", 32'(g_ov), 32'd0);
    chk("fl_od", 32'(g_od), 32'd0);
    chk("fl_ir", 32'(g_ir), 32'd0);
    step();
    flush = 1'b0; iv = 1'b0; ordy = 1'b0;
    #1;
    chk("fl_post_cnt", 32'(g_cnt), 32'd0);
    chk("fl_post_ov", 32'(g_ov), 32'd0);
    chk("fl_post_od", 32'(g_od), 32'd0);
`ifdef LIEAT_PIPEBUF_PEAK_EN
    chk("fl_post_peak", 32'(g_peak), 32'd0);
`endif

    // ---- reset mid-operation discards stored and in-flight items ----
    iv = 1'b1; id = 8'hE1;
    step();
    id = 8'hE2;
    step();
    rstn = 1'b0; id = 8'hE3;
    step();
    rstn = 1'b1; iv = 1'b0;
    #1;
    chk("mrst_cnt", 32'(g_cnt), 32'd0);
    chk("mrst_ov", 32'(g_ov), 32'd0);
    chk("mrst_od", 32'(g_od), 32'd0);
    step();
    chk("mrst_hold", 32'(g_cnt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
